// File: rtl/uart_pkg.sv
// Shared UART definitions for the RX and TX paths: FSM state encoding,
// oversampling constants and the 3-sample majority helper.
package uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } uart_rx_state_t;

  localparam int OS_RATE    = 16;
  localparam int SAMPLE_LO  = 7;
  localparam int SAMPLE_MID = 8;
  localparam int SAMPLE_HI  = 9;
  localparam int OS_W       = $clog2(OS_RATE);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one tick every OS_DIV clocks, with a synchronous
// clear so the tick phase can be realigned to an incoming edge.
module uart_baud_gen #(
  parameter int OS_DIV = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int W = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(OS_DIV - 1);

  logic [W-1:0] div_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      div_cnt <= '0;
    else if (clear || div_cnt == LAST)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + 1'b1;
  end

  // A clear restarts the count, so no tick may escape in the same cycle.
  assign tick = (div_cnt == LAST) && !clear;

endmodule

// File: rtl/uart_rx_receiver.sv
// 16x-oversampled UART receiver (start, DATA_BITS LSB-first, one stop bit)
// with majority voting and a valid/ready output register.
module uart_rx_receiver
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int OS_DIV    = 27
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_in,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0]   LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [OS_W-1:0] OS_LO    = OS_W'(SAMPLE_LO);
  localparam logic [OS_W-1:0] OS_MID   = OS_W'(SAMPLE_MID);
  localparam logic [OS_W-1:0] OS_HI    = OS_W'(SAMPLE_HI);
  localparam logic [OS_W-1:0] OS_LAST  = OS_W'(OS_RATE - 1);

  uart_rx_state_t       state;
  logic                 sync1, sync2, rx_s, rx_prev;
  logic [1:0]           fill;
  logic                 start_det, clr, tick;
  logic [OS_W-1:0]      os_cnt;
  logic                 s_lo, s_mid, maj;
  logic                 at_hi, at_end;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;

  // rx_prev only ever loads real line samples: the reset value of the
  // synchronizer is not trusted, so a line held low through reset is no start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      fill    <= 2'b00;
      rx_prev <= 1'b0;
    end else begin
      sync1   <= rx_in;
      sync2   <= sync1;
      fill    <= {fill[0], 1'b1};
      rx_prev <= fill[1] & sync2;
    end
  end

  assign rx_s      = sync2;
  assign start_det = rx_prev & ~rx_s;
  assign clr       = (state == RX_IDLE) && start_det;

  uart_baud_gen #(.OS_DIV(OS_DIV)) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (clr),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      os_cnt <= '0;
      s_lo   <= 1'b1;
      s_mid  <= 1'b1;
    end else begin
      if (clr)
        os_cnt <= '0;
      else if (tick)
        os_cnt <= os_cnt + 1'b1;
      if (tick && os_cnt == OS_LO)  s_lo  <= rx_s;
      if (tick && os_cnt == OS_MID) s_mid <= rx_s;
    end
  end

  // Third vote is the live sample on the os_cnt=9 tick.
  assign maj    = maj3(s_lo, s_mid, rx_s);
  assign at_hi  = tick && (os_cnt == OS_HI);
  assign at_end = tick && (os_cnt == OS_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RX_IDLE;
      busy        <= 1'b0;
      bit_cnt     <= '0;
      shreg       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (rx_valid && rx_ready)
        rx_valid <= 1'b0;

      case (state)
        RX_IDLE: begin
          if (start_det) begin
            state <= RX_START;
            busy  <= 1'b1;
          end
        end
        RX_START: begin
          if (at_hi && maj) begin
            state <= RX_IDLE;
            busy  <= 1'b0;
          end else if (at_end) begin
            state   <= RX_DATA;
            bit_cnt <= '0;
          end
        end
        RX_DATA: begin
          if (at_hi)
            shreg <= {maj, shreg[DATA_BITS-1:1]};
          if (at_end) begin
            if (bit_cnt == LAST_BIT)
              state <= RX_STOP;
            else
              bit_cnt <= bit_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          // Leave mid-stop-bit so a back-to-back start edge is not missed.
          if (at_hi) begin
            state       <= RX_IDLE;
            busy        <= 1'b0;
            rx_data     <= shreg;
            rx_valid    <= 1'b1;
            frame_err   <= ~maj;
            overrun_err <= rx_valid && !rx_ready;
          end
        end
        default: begin
          state <= RX_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_receiver.sv
// Bench for uart_rx_receiver: directed corner frames plus random frames,
// checked against a word-level queue model of the serial stream.
module tb_uart_rx_receiver;

  localparam int DB      = 8;
  localparam int OSD     = 4;
  localparam int BIT_CLK = 16 * OSD;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx_in = 1'b1;
  logic          rx_ready = 1'b1;
  logic [DB-1:0] rx_data;
  logic          rx_valid, frame_err, overrun_err, busy;

  uart_rx_receiver #(.DATA_BITS(DB), .OS_DIV(OSD)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_in       (rx_in),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [DB-1:0] data;
    logic          ferr;
  } word_t;

  word_t exp_q[$];
  word_t w;
  bit    hold = 1'b0;
  int    exp_ovr = 0, ovr_seen = 0;
  int    cyc = 0, start_cyc = 0, last_dlv = 0;

  always @(posedge clk) cyc++;

  // A word not consumed before the next one arrives is replaced by it.
  task automatic model_push(input logic [DB-1:0] d, input logic ferr);
    word_t nw;
    nw.data = d;
    nw.ferr = ferr;
    if (hold && exp_q.size() > 0) begin
      exp_q[exp_q.size()-1] = nw;
      exp_ovr++;
    end else
      exp_q.push_back(nw);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (overrun_err) ovr_seen++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0)
          check("spurious_word", {31'd0, rx_valid}, 32'd0);
        else begin
          w = exp_q.pop_front();
          check("rx_data", {24'd0, rx_data}, {24'd0, w.data});
          check("frame_err", {31'd0, frame_err}, {31'd0, w.ferr});
          last_dlv = cyc;
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive_bit(input logic b);
    rx_in = b;
    wait_clk(BIT_CLK);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop_ok);
    model_push(d, ~stop_ok);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    drive_bit(stop_ok);
    rx_in = 1'b1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data"},  {24'd0, rx_data}, 32'd0);
    check({tag, "_valid"}, {31'd0, rx_valid}, 32'd0);
    check({tag, "_ferr"},  {31'd0, frame_err}, 32'd0);
    check({tag, "_ovr"},   {31'd0, overrun_err}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [DB-1:0] d;
    logic          ok;
    int            lat;

    wait_clk(3);
    check_outputs_zero("reset");
    reset = 1'b0;
    wait_clk(20);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Good frame, latency from start edge to rx_valid
    last_dlv = 0;
    send_frame(8'hA5, 1'b1);
    lat = last_dlv - start_cyc;
    check("latency_in_window", {31'd0, (lat >= 600 && lat <= 630)}, 32'd1);
    check("t1_drain", exp_q.size(), 32'd0);
    wait_clk(30);

    // 8-clk low glitch is a false start
    rx_in = 1'b0;
    wait_clk(8);
    rx_in = 1'b1;
    wait_clk(4);
    check("glitch_busy", {31'd0, busy}, 32'd1);
    wait_clk(60);
    check("glitch_idle", {31'd0, busy}, 32'd0);
    check("glitch_valid", {31'd0, rx_valid}, 32'd0);
    wait_clk(40);

    // Bad stop bit: word still delivered, flagged
    send_frame(8'h3C, 1'b0);
    wait_clk(BIT_CLK);
    check("t3_drain", exp_q.size(), 32'd0);

    // Back-to-back with consumer stalled
    rx_ready = 1'b0;
    hold = 1'b1;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    wait_clk(10);
    check("ovr_valid", {31'd0, rx_valid}, 32'd1);
    check("ovr_data", {24'd0, rx_data}, 32'h22);
    check("ovr_count", ovr_seen, exp_ovr);
    rx_ready = 1'b1;
    hold = 1'b0;
    wait_clk(5);
    check("t4_drain", exp_q.size(), 32'd0);
    check("ovr_valid_clear", {31'd0, rx_valid}, 32'd0);

    // Reset during data bit 4 with the line low
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rx_in = 1'b0;
    wait_clk(30);
    reset = 1'b1;
    wait_clk(2);
    check_outputs_zero("midreset");
    reset = 1'b0;
    wait_clk(40);
    check("lowline_busy", {31'd0, busy}, 32'd0);
    check("lowline_valid", {31'd0, rx_valid}, 32'd0);
    rx_in = 1'b1;
    wait_clk(2 * BIT_CLK);
    check("post_reset_busy", {31'd0, busy}, 32'd0);
    send_frame(8'h5A, 1'b1);
    check("t5_drain", exp_q.size(), 32'd0);
    wait_clk(20);

    // 0x00 with a 1-clk spike landing on the middle vote of bit 3
    model_push(8'h00, 1'b0);
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0);
    rx_in = 1'b0;
    wait_clk(36);
    rx_in = 1'b1;
    wait_clk(1);
    rx_in = 1'b0;
    wait_clk(BIT_CLK - 37);
    for (int i = 4; i < DB; i++) drive_bit(1'b0);
    drive_bit(1'b1);
    rx_in = 1'b1;
    check("t6_drain", exp_q.size(), 32'd0);
    wait_clk(20);

    // Random frames, random stop bits and idle gaps
    for (int n = 0; n < 12; n++) begin
      d  = DB'($urandom_range(0, 255));
      ok = ($urandom_range(0, 3) != 0);
      send_frame(d, ok);
      wait_clk(ok ? $urandom_range(0, 80) : $urandom_range(8, 80));
    end
    wait_clk(BIT_CLK);
    check("rand_drain", exp_q.size(), 32'd0);
    check("overrun_total", ovr_seen, exp_ovr);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
